// File: rtl/alu_pkg.sv
// Shared opcode, state and flag definitions for the pipelined ALU.
package alu_pkg;

    // Opcodes 0-3 keep the encoding of the original combinational ALU
    localparam logic [2:0] OP_FWD = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRA = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    // Control states: IDLE accepts work, MUL blocks input while iterating
    localparam logic S_IDLE = 1'b0;
    localparam logic S_MUL  = 1'b1;

    // Status flags, independent of the datapath width
    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic               busy;

    assign busy = (count != '0);

    // done marks the final iteration; product is then the complete result
    assign done    = (count == CW'(1));
    assign product = mplier[0] ? (acc + mcand) : acc;

    // Latch operands on start, then add/shift once per edge until the count runs out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
        end else if (start) begin
            count  <= CW'(WIDTH);
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
        end else if (busy) begin
            count  <= count - CW'(1);
            mcand  <= mcand << 1;
            acc    <= product;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake on both sides and an iterative multiply.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] INPUT1,
    input  logic [WIDTH-1:0] INPUT2,
    input  logic [2:0]       SELECT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUTPUT,
    output logic             ZERO,
    output logic             CARRY,
    output logic             OVERFLOW
);

    import alu_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    logic               state;
    logic               ready_en;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    alu_flags_t         flags;

    logic               accept;
    logic               mul_start;
    logic               single_accept;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   op_result;
    logic               op_carry;
    logic               op_ovf;
    alu_flags_t         op_flags;
    alu_flags_t         mul_flags;

    assign IN_READY      = ready_en && (state == S_IDLE) && (!out_valid || OUT_READY);
    assign accept        = IN_VALID && IN_READY;
    assign mul_start     = accept && (SELECT == OP_MUL);
    assign single_accept = accept && (SELECT != OP_MUL);

    assign sum   = {1'b0, INPUT1} + {1'b0, INPUT2};
    assign diff  = {1'b0, INPUT1} - {1'b0, INPUT2};
    assign shamt = INPUT2[SHW-1:0];

    assign OUT_VALID = out_valid;
    assign OUTPUT    = out_data;
    assign ZERO      = flags.zero;
    assign CARRY     = flags.carry;
    assign OVERFLOW  = flags.overflow;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .start   (mul_start),
        .a       (INPUT1),
        .b       (INPUT2),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle op decode; carry is the borrow on SUB, overflow is signed
    always_comb begin
        op_result = INPUT1;
        op_carry  = 1'b0;
        op_ovf    = 1'b0;
        case (SELECT)
            OP_FWD: op_result = INPUT1;
            OP_ADD: begin
                op_result = sum[WIDTH-1:0];
                op_carry  = sum[WIDTH];
                op_ovf    = (INPUT1[WIDTH-1] == INPUT2[WIDTH-1]) &&
                            (sum[WIDTH-1] != INPUT1[WIDTH-1]);
            end
            OP_AND: op_result = INPUT1 & INPUT2;
            OP_OR:  op_result = INPUT1 | INPUT2;
            OP_SUB: begin
                op_result = diff[WIDTH-1:0];
                op_carry  = diff[WIDTH];
                op_ovf    = (INPUT1[WIDTH-1] != INPUT2[WIDTH-1]) &&
                            (diff[WIDTH-1] != INPUT1[WIDTH-1]);
            end
            OP_SLL: op_result = INPUT1 << shamt;
            OP_SRA: op_result = $signed(INPUT1) >>> shamt;
            default: op_result = INPUT1;
        endcase
        op_flags.zero     = (op_result == '0);
        op_flags.carry    = op_carry;
        op_flags.overflow = op_ovf;
        mul_flags.zero     = (mul_product[WIDTH-1:0] == '0);
        mul_flags.carry    = (mul_product[2*WIDTH-1:WIDTH] != '0);
        mul_flags.overflow = 1'b0;
    end

    // Input side stays closed until the first edge after reset is released
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // FSM: leave IDLE on an accepted multiply, return when the multiplier finishes
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else if (state == S_IDLE) begin
            if (mul_start) begin
                state <= S_MUL;
            end
        end else if (mul_done) begin
            state <= S_IDLE;
        end
    end

    // Output register: load a finished result, otherwise hold until consumed
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            flags     <= '0;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            out_data  <= mul_product[WIDTH-1:0];
            flags     <= mul_flags;
        end else if (single_accept) begin
            out_valid <= 1'b1;
            out_data  <= op_result;
            flags     <= op_flags;
        end else if (out_valid && OUT_READY) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8.
module tb_alu_pipe;

    logic       clk;
    logic       resetN;
    logic       inValid;
    logic       inReady;
    logic [7:0] input1;
    logic [7:0] input2;
    logic [2:0] select;
    logic       outValid;
    logic       outReady;
    logic [7:0] outData;
    logic       zero;
    logic       carry;
    logic       overflow;

    int         assertCount;
    int         failCount;
    logic [7:0] taken[$];

    alu_pipe #(
        .WIDTH (8)
    ) dut (
        .CLK       (clk),
        .RESET_N   (resetN),
        .IN_VALID  (inValid),
        .IN_READY  (inReady),
        .INPUT1    (input1),
        .INPUT2    (input2),
        .SELECT    (select),
        .OUT_VALID (outValid),
        .OUT_READY (outReady),
        .OUTPUT    (outData),
        .ZERO      (zero),
        .CARRY     (carry),
        .OVERFLOW  (overflow)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every result the consumer takes, sampled mid-cycle
    always @(negedge clk) begin
        if (outValid && outReady) begin
            taken.push_back(outData);
        end
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        inValid = valid;
        select  = sel;
        input1  = a;
        input2  = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResult(input string tag, input logic [7:0] expOut, input logic expZ, input logic expC, input logic expV);
        checkOutput({tag, ".valid"}, 32'(outValid), 32'd1);
        checkOutput({tag, ".out"},   32'(outData),  32'(expOut));
        checkOutput({tag, ".zero"},  32'(zero),     32'(expZ));
        checkOutput({tag, ".carry"}, 32'(carry),    32'(expC));
        checkOutput({tag, ".ovf"},   32'(overflow), 32'(expV));
    endtask

    task automatic runSingle(input string tag, input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] expOut, input logic expZ, input logic expC, input logic expV);
        applyStimulus(1'b1, sel, a, b);
        tick();
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
        checkResult(tag, expOut, expZ, expC, expV);
        tick();
    endtask

    task automatic runMul(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] expOut, input logic expZ, input logic expC);
        applyStimulus(1'b1, 3'd7, a, b);
        tick();
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            checkOutput($sformatf("%s.inReadyBusy%0d", tag, i), 32'(inReady), 32'd0);
            checkOutput($sformatf("%s.validEarly%0d", tag, i), 32'(outValid), 32'd0);
            tick();
        end
        checkResult(tag, expOut, expZ, expC, 1'b0);
        tick();
    endtask

    logic [2:0] b2bSel [5];
    logic [7:0] b2bExp [5];

    initial begin
        assertCount = 0;
        failCount   = 0;
        b2bSel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        b2bExp = '{8'h03, 8'h04, 8'h01, 8'h03, 8'h02};

        resetN   = 1'b1;
        outReady = 1'b1;
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);

        // Reset asserted before any clock edge must clear outputs on its own
        #1 resetN = 1'b0;
        #2;
        checkOutput("rst.valid",   32'(outValid), 32'd0);
        checkOutput("rst.out",     32'(outData),  32'd0);
        checkOutput("rst.zero",    32'(zero),     32'd0);
        checkOutput("rst.carry",   32'(carry),    32'd0);
        checkOutput("rst.ovf",     32'(overflow), 32'd0);
        checkOutput("rst.inReady", 32'(inReady),  32'd0);
        repeat (3) tick();
        checkOutput("rstClocked.inReady", 32'(inReady), 32'd0);
        resetN = 1'b1;
        #1;
        checkOutput("rstRelease.inReady", 32'(inReady), 32'd0);
        tick();
        checkOutput("postReset.inReady", 32'(inReady), 32'd1);

        // Back-to-back single-cycle ops at full throughput
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, b2bSel[i], 8'h03, 8'h01);
            tick();
            checkOutput($sformatf("b2b%0d.valid", i), 32'(outValid), 32'd1);
            checkOutput($sformatf("b2b%0d.out", i),   32'(outData),  32'(b2bExp[i]));
        end
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
        tick();
        checkOutput("b2bDrained.valid", 32'(outValid), 32'd0);

        // Flag corner cases
        runSingle("addWrap", 3'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
        runSingle("addOvf",  3'd1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
        runSingle("subBorrow", 3'd4, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b1, 1'b0);
        runSingle("sll",     3'd5, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        runSingle("sra",     3'd6, 8'h90, 8'h02, 8'hE4, 1'b0, 1'b0, 1'b0);

        // Iterative multiply latency and high-half carry
        runMul("mulSmall", 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0);
        runMul("mulHigh",  8'h10, 8'h20, 8'h00, 1'b1, 1'b1);

        // Back-pressure: second op must wait while first result is held
        outReady = 1'b0;
        applyStimulus(1'b1, 3'd1, 8'h01, 8'h01);
        tick();
        checkOutput("bp.first", 32'(outData), 32'h02);
        checkOutput("bp.valid", 32'(outValid), 32'd1);
        checkOutput("bp.inReady", 32'(inReady), 32'd0);
        applyStimulus(1'b1, 3'd1, 8'h02, 8'h02);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput($sformatf("bpHold%0d.out", i),     32'(outData), 32'h02);
            checkOutput($sformatf("bpHold%0d.inReady", i), 32'(inReady), 32'd0);
        end
        taken.delete();
        outReady = 1'b1;
        #1;
        checkOutput("bpOpen.inReady", 32'(inReady), 32'd1);
        tick();
        checkOutput("bpSecond.out",   32'(outData),  32'h04);
        checkOutput("bpSecond.valid", 32'(outValid), 32'd1);
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
        tick();
        checkOutput("bpDrained.valid", 32'(outValid), 32'd0);
        tick();
        checkOutput("bp.takenCount", 32'(taken.size()), 32'd2);
        if (taken.size() == 2) begin
            checkOutput("bp.taken0", 32'(taken[0]), 32'h02);
            checkOutput("bp.taken1", 32'(taken[1]), 32'h04);
        end

        // Reset in the middle of a multiply discards it immediately
        applyStimulus(1'b1, 3'd7, 8'h0D, 8'h0B);
        tick();
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (3) tick();
        #2 resetN = 1'b0;
        #1;
        checkOutput("midMulRst.valid",   32'(outValid), 32'd0);
        checkOutput("midMulRst.out",     32'(outData),  32'd0);
        checkOutput("midMulRst.inReady", 32'(inReady),  32'd0);
        taken.delete();
        repeat (2) tick();
        resetN = 1'b1;
        repeat (10) tick();
        checkOutput("midMulRst.noResult", 32'(outValid), 32'd0);
        checkOutput("midMulRst.noTaken",  32'(taken.size()), 32'd0);
        checkOutput("midMulRst.inReadyBack", 32'(inReady), 32'd1);
        runSingle("addAfterRst", 3'd1, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
